count_checker: RTL and testbench

Sequence checker that sits on the receiving end of a free-running wrap-around up-counter. It samples the counter value and verifies that each valid sample is exactly the previous sample plus one, modulo 2^WIDTH. It acquires lock after a run of correct increments and reports errors while locked. It keeps a saturating error count and drops lock after repeated consecutive errors.

---
 rtl/count_checker.sv | 133 +++++++++++++
 tb/tb_count_checker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// Purpose: checks that a sampled free-running wrap-around counter advances by
//          exactly one per valid sample; acquires lock, flags errors, drops lock.
// Latency: one cycle from the sampling edge to locked/error/err_count/expected.
// Backpressure: none; samples are taken whenever valid_in is high.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   count_in, valid_in observed counter value and its sample strobe
//   clear              synchronous clear of err_count (wins over increment)
//   locked             high while locked or slipping
//   error              one-cycle pulse per mismatch seen while locked
//   err_count          saturating mismatch count
//   expected           next expected value (last sample + 1)
module count_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 3,
    parameter int ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    count_in,
    input  logic                valid_in,
    input  logic                clear,
    output logic                locked,
    output logic                error,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [WIDTH-1:0]    expected
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(ERR_LIMIT + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
    localparam logic [BW-1:0] ERR_V  = BW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [WIDTH-1:0] prev;
    logic [GW-1:0] good_run, good_nx, good_inc;
    logic [BW-1:0] bad_run, bad_nx, bad_inc;
    logic          err_nx;
    logic          match;

    // Wrap from all-ones to zero falls out of the WIDTH-bit add.
    assign match    = (count_in == prev + WIDTH'(1));
    assign good_inc = good_run + GW'(1);
    assign bad_inc  = bad_run + BW'(1);
    assign expected = prev + WIDTH'(1);

    always_comb begin
        state_nx = state;
        good_nx  = good_run;
        bad_nx   = bad_run;
        err_nx   = 1'b0;
        if (valid_in) begin
            case (state)
                IDLE: begin
                    // First sample only seeds prev; nothing to compare against.
                    good_nx  = '0;
                    state_nx = SEARCH;
                end
                SEARCH: begin
                    if (match) begin
                        good_nx = good_inc;
                        if (good_inc == LOCK_V) begin
                            state_nx = LOCKED;
                            bad_nx   = '0;
                        end
                    end else begin
                        good_nx = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        err_nx = 1'b1;
                        bad_nx = BW'(1);
                        if (ERR_LIMIT == 1) begin
                            state_nx = SEARCH;
                            good_nx  = '0;
                        end else begin
                            state_nx = SLIP;
                        end
                    end
                end
                SLIP: begin
                    if (match) begin
                        bad_nx   = '0;
                        state_nx = LOCKED;
                    end else begin
                        err_nx = 1'b1;
                        bad_nx = bad_inc;
                        if (bad_inc == ERR_V) begin
                            state_nx = SEARCH;
                            good_nx  = '0;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev      <= '1;
            good_run  <= '0;
            bad_run   <= '0;
            error     <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_nx;
            good_run <= good_nx;
            bad_run  <= bad_nx;
            error    <= err_nx;
            locked   <= (state_nx == LOCKED) || (state_nx == SLIP);
            // Re-sync to whatever was received so one glitch costs one error.
            if (valid_in) prev <= count_in;
            if (clear)
                err_count <= '0;
            else if (err_nx && (err_count != '1))
                err_count <= err_count + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_count_checker.sv
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic       valid_in = 1'b0;
    logic       clear = 1'b0;

    logic       locked0, error0, locked1, error1;
    logic [7:0] errcnt0;
    logic [1:0] errcnt1;
    logic [3:0] exp0, exp1;

    always #5 clk = ~clk;

    count_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_LIMIT(3), .ERRCNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .valid_in(valid_in),
        .clear(clear), .locked(locked0), .error(error0), .err_count(errcnt0),
        .expected(exp0)
    );

    count_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_LIMIT(3), .ERRCNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .valid_in(valid_in),
        .clear(clear), .locked(locked1), .error(error1), .err_count(errcnt1),
        .expected(exp1)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference: lock is a boolean, the runs are plain integers.
    bit m_started[2], m_lock[2], m_err[2];
    int m_prev[2], m_good[2], m_bad[2], m_cnt[2];
    int lim[2] = '{255, 3};

    task automatic chk(input string tag, input int obs, input int exp_v);
        nchk++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_started[i] = 0; m_lock[i] = 0; m_err[i] = 0;
            m_prev[i] = 15; m_good[i] = 0; m_bad[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_update(input bit v, input int c, input bit clr);
        bit m;
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 0;
            if (v) begin
                m = (c == (m_prev[i] + 1) % 16);
                if (!m_started[i]) begin
                    m_started[i] = 1;
                    m_good[i] = 0;
                end else if (!m_lock[i]) begin
                    m_good[i] = m ? m_good[i] + 1 : 0;
                    if (m_good[i] == 4) begin
                        m_lock[i] = 1;
                        m_bad[i] = 0;
                    end
                end else if (m) begin
                    m_bad[i] = 0;
                end else begin
                    m_err[i] = 1;
                    if (m_cnt[i] < lim[i]) m_cnt[i]++;
                    m_bad[i]++;
                    if (m_bad[i] == 3) begin
                        m_lock[i] = 0;
                        m_good[i] = 0;
                    end
                end
                m_prev[i] = c;
            end
            if (clr) m_cnt[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked0"}, int'(locked0), int'(m_lock[0]));
        chk({tag, ".error0"},  int'(error0),  int'(m_err[0]));
        chk({tag, ".errcnt0"}, int'(errcnt0), m_cnt[0]);
        chk({tag, ".exp0"},    int'(exp0),    (m_prev[0] + 1) % 16);
        chk({tag, ".locked1"}, int'(locked1), int'(m_lock[1]));
        chk({tag, ".error1"},  int'(error1),  int'(m_err[1]));
        chk({tag, ".errcnt1"}, int'(errcnt1), m_cnt[1]);
        chk({tag, ".exp1"},    int'(exp1),    (m_prev[1] + 1) % 16);
    endtask

    task automatic step(input string tag, input bit v, input int c, input bit clr);
        valid_in = v;
        count_in = 4'(c);
        clear    = clr;
        @(posedge clk);
        model_update(v, c, clr);
        #1;
        check_all(tag);
    endtask

    int seq_acq[]  = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0,1,2};
    int seq_gl[]   = '{3,4,9,10,11};
    int seq_loss[] = '{12,13,14,15,0,1,2,3,4,9,2,7,8,9,10,11};
    int seq_sat[]  = '{0,1,5,6,0,1,9,10,3,4,12,13,14,15,0,1};

    initial begin
        int c;
        bit v, clr;

        // Reset held with the clock running.
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        #3 rst_n = 1'b1;

        // No valid samples: nothing moves.
        for (int i = 0; i < 3; i++) step("idle", 0, 7, 0);

        foreach (seq_acq[i])  step("acq", 1, seq_acq[i], 0);
        chk("acq.locked_final", int'(locked0), 1);
        foreach (seq_gl[i])   step("glitch", 1, seq_gl[i], 0);
        chk("glitch.errcnt", int'(errcnt0), 1);
        foreach (seq_loss[i]) step("loss", 1, seq_loss[i], 0);
        foreach (seq_sat[i])  step("sat", 1, seq_sat[i], 0);
        chk("sat.errcnt1", int'(errcnt1), 3);

        // Mismatch while locked with clear on the same edge.
        step("clr_err", 1, 9, 1);
        chk("clr_err.error", int'(error0), 1);
        chk("clr_err.errcnt", int'(errcnt0), 0);
        for (int i = 10; i < 16; i++) step("relock", 1, i, 0);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        #2 rst_n = 1'b1;

        // Re-acquire with gaps between valid samples.
        for (int i = 5; i < 10; i++) begin
            step("gap_v", 1, i, 0);
            step("gap_n", 0, 3, 0);
        end
        chk("gap.locked", int'(locked0), 1);

        // Randomised run against the reference.
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 40) == 0);
            c   = ($urandom_range(0, 9) < 8) ? (m_prev[0] + 1) % 16
                                             : int'($urandom_range(0, 15));
            step("rand", v, c, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
